// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone B3 round-robin arbiter; grant is held for the whole cyc tenure.
// Optional slave-stall watchdog enabled with `define WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        m_cyc_i,
    input  logic [1:0]        m_stb_i,
    input  logic [1:0]        m_we_i,
    input  logic [2*AW-1:0]   m_adr_i,
    input  logic [2*DW/8-1:0] m_sel_i,
    input  logic [2*DW-1:0]   m_dat_i,
    input  logic [5:0]        m_cti_i,
    input  logic [3:0]        m_bte_i,
    output logic [1:0]        m_ack_o,
    output logic [1:0]        m_err_o,
    output logic [1:0]        m_rty_o,
    output logic [2*DW-1:0]   m_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [2:0]        s_cti_o,
    output logic [1:0]        s_bte_o,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_rty_i,
    input  logic [DW-1:0]     s_dat_i,
    output logic [1:0]        gnt_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    state_t state;
    logic   last;
    logic   owner;
    logic   granted;
    logic   kill;
    logic   timeout_hit;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: reset is synchronous; it only takes effect on a rising clk edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m_cyc_i == 2'b11)  state <= last ? GNT0 : GNT1;
                    else if (m_cyc_i[0])   state <= GNT0;
                    else if (m_cyc_i[1])   state <= GNT1;
                end
                GNT0: begin
                    if (!m_cyc_i[0]) begin
                        last  <= 1'b0;
                        state <= m_cyc_i[1] ? GNT1 : IDLE;
                    end
                end
                GNT1: begin
                    if (!m_cyc_i[1]) begin
                        last  <= 1'b1;
                        state <= m_cyc_i[0] ? GNT0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_o   = {state == GNT1, state == GNT0};
    assign granted = |gnt_o;
    assign owner   = (state == GNT1);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;
    logic          release_now;
    logic          slave_resp;

    assign release_now = (state == GNT0 && !m_cyc_i[0]) || (state == GNT1 && !m_cyc_i[1]);
    assign slave_resp  = s_ack_i | s_err_i | s_rty_i;
    assign timeout_hit = granted && (count == CW'(TIMEOUT_CYCLES));

    // Once the watchdog fires, the owner is cut off from the slave until it drops cyc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            kill  <= 1'b0;
        end else begin
            if (!granted || release_now || slave_resp || timeout_hit)
                count <= '0;
            else if (s_cyc_o && s_stb_o)
                count <= count + 1'b1;

            if (!granted || release_now) kill <= 1'b0;
            else if (timeout_hit)        kill <= 1'b1;
        end
    end
`else
    assign kill        = 1'b0;
    assign timeout_hit = 1'b0;
`endif

    // Slave side: pure mux of the owner's request, zero when idle; independent of slave responses.
    assign s_cyc_o = |(m_cyc_i & gnt_o) & ~kill;
    assign s_stb_o = |(m_stb_i & gnt_o) & ~kill;
    assign s_we_o  = |(m_we_i & gnt_o);
    assign s_adr_o = granted ? m_adr_i[owner*AW +: AW]         : '0;
    assign s_sel_o = granted ? m_sel_i[owner*(DW/8) +: (DW/8)] : '0;
    assign s_dat_o = granted ? m_dat_i[owner*DW +: DW]         : '0;
    assign s_cti_o = granted ? m_cti_i[owner*3 +: 3]           : '0;
    assign s_bte_o = granted ? m_bte_i[owner*2 +: 2]           : '0;

    assign m_ack_o = gnt_o & {2{s_ack_i}};
    assign m_err_o = gnt_o & {2{s_err_i | timeout_hit}};
    assign m_rty_o = gnt_o & {2{s_rty_i}};
    assign m_dat_o = {2{s_dat_i}};

endmodule
